pipe_skid_ingress: RTL and testbench

- Ingress stage that sits directly upstream of the enable-driven typed pipeline register.
- Converts a valid/ready producer interface into a registered, stall-tolerant stream using a 2-entry skid buffer.
- Decodes a 2-bit packet type into one-hot type_a/type_b qualifiers.
- Flags and counts illegal types, so the downstream stage sees clean in_vld/type_a/type_b/data with full throughput and registered backpressure.

---
 rtl/pipe_skid_ingress.sv | 151 +++++++++++++++
 tb/tb_pipe_skid_ingress.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_ingress.sv
// pipe_skid_ingress
//   Ingress stage for the typed pipeline register. It takes a valid/ready
//   producer stream and presents a registered, stall-tolerant stream through a
//   2-entry skid buffer. The 2-bit packet type is decoded into one-hot
//   type_a/type_b flags when an entry is captured. Entries with the illegal
//   type 11 still pass through as common-only, and they are flagged and counted.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   s_vld/s_rdy               producer handshake (s_rdy is registered)
//   s_type, s_data_*          producer packet type and payload fields
//   m_vld/m_rdy               downstream handshake (m_rdy = downstream enable)
//   m_type_a/m_type_b         decoded type flags of the head entry
//   m_data_*                  head entry payload fields
//   occupancy                 entries held (0..2)
//   err_illegal               one-cycle pulse after an illegal type is accepted
//   err_cnt                   saturating count of accepted illegal types
module pipe_skid_ingress #(
    parameter int COMMON_W  = 8,
    parameter int A_W       = 8,
    parameter int B_W       = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_vld,
    output logic                 s_rdy,
    input  logic [1:0]           s_type,
    input  logic [COMMON_W-1:0]  s_data_common,
    input  logic [A_W-1:0]       s_data_a,
    input  logic [B_W-1:0]       s_data_b,
    output logic                 m_vld,
    input  logic                 m_rdy,
    output logic                 m_type_a,
    output logic                 m_type_b,
    output logic [COMMON_W-1:0]  m_data_common,
    output logic [A_W-1:0]       m_data_a,
    output logic [B_W-1:0]       m_data_b,
    output logic [1:0]           occupancy,
    output logic                 err_illegal,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef struct packed {
        logic                type_a;
        logic                type_b;
        logic [COMMON_W-1:0] common;
        logic [A_W-1:0]      a;
        logic [B_W-1:0]      b;
    } entry_t;

    // The encoding equals the occupancy, so the occupancy output is the state register.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    entry_t               main_q, main_d;
    entry_t               skid_q, skid_d;
    entry_t               in_entry;
    logic                 s_rdy_q, s_rdy_d;
    logic                 err_illegal_q, err_illegal_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 in_fire, out_fire;

    always_comb begin
        in_entry.type_a = (s_type == 2'b01);
        in_entry.type_b = (s_type == 2'b10);
        in_entry.common = s_data_common;
        in_entry.a      = s_data_a;
        in_entry.b      = s_data_b;

        in_fire  = s_vld & s_rdy_q;
        out_fire = (state_q != EMPTY) & m_rdy;

        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    main_d  = in_entry;
                end
            end
            ONE: begin
                if (in_fire && !out_fire) begin
                    state_d = FULL;
                    skid_d  = in_entry;
                end else if (in_fire && out_fire) begin
                    main_d  = in_entry;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // s_rdy is low here, so only the drain side can move.
                if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Readiness comes only from the next state. This keeps m_rdy off any
        // combinational path to s_rdy.
        s_rdy_d       = (state_d != FULL);
        err_illegal_d = in_fire & (s_type == 2'b11);
        err_cnt_d     = err_cnt_q;
        if (err_illegal_d && (err_cnt_q != {ERR_CNT_W{1'b1}}))
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= EMPTY;
            s_rdy_q       <= 1'b1;
            err_illegal_q <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            s_rdy_q       <= s_rdy_d;
            err_illegal_q <= err_illegal_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    // Payload registers have no reset. m_vld qualifies their contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign s_rdy         = s_rdy_q;
    assign m_vld         = (state_q != EMPTY);
    assign m_type_a      = main_q.type_a;
    assign m_type_b      = main_q.type_b;
    assign m_data_common = main_q.common;
    assign m_data_a      = main_q.a;
    assign m_data_b      = main_q.b;
    assign occupancy     = state_q;
    assign err_illegal   = err_illegal_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_pipe_skid_ingress.sv
// Testbench for pipe_skid_ingress. The reference model is a depth-2 FIFO held
// in a queue, plus an expected error pulse and a saturating counter.
module tb_pipe_skid_ingress;

    localparam int CW = 8, AW = 8, BW = 8, EW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_vld = 1'b0, s_rdy;
    logic [1:0]    s_type = '0;
    logic [CW-1:0] s_data_common = '0;
    logic [AW-1:0] s_data_a = '0;
    logic [BW-1:0] s_data_b = '0;
    logic          m_vld, m_rdy = 1'b0, m_type_a, m_type_b;
    logic [CW-1:0] m_data_common;
    logic [AW-1:0] m_data_a;
    logic [BW-1:0] m_data_b;
    logic [1:0]    occupancy;
    logic          err_illegal;
    logic [EW-1:0] err_cnt;

    pipe_skid_ingress #(.COMMON_W(CW), .A_W(AW), .B_W(BW), .ERR_CNT_W(EW)) dut (
        .clk(clk), .rst(rst), .s_vld(s_vld), .s_rdy(s_rdy), .s_type(s_type),
        .s_data_common(s_data_common), .s_data_a(s_data_a), .s_data_b(s_data_b),
        .m_vld(m_vld), .m_rdy(m_rdy), .m_type_a(m_type_a), .m_type_b(m_type_b),
        .m_data_common(m_data_common), .m_data_a(m_data_a), .m_data_b(m_data_b),
        .occupancy(occupancy), .err_illegal(err_illegal), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    ty;
        logic [CW-1:0] c;
        logic [AW-1:0] a;
        logic [BW-1:0] b;
    } ment_t;

    ment_t mq[$];
    bit    exp_err;
    int    exp_cnt;
    int    total = 0, bad = 0;

    // Advance one clock and update the model from the inputs sampled at the edge.
    task automatic tick();
        bit inf, outf;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            exp_err = 0;
            exp_cnt = 0;
        end else begin
            inf  = s_vld && (mq.size() < 2);
            outf = m_rdy && (mq.size() > 0);
            exp_err = inf && (s_type == 2'b11);
            if (outf) void'(mq.pop_front());
            if (inf) begin
                mq.push_back('{s_type, s_data_common, s_data_a, s_data_b});
                if (s_type == 2'b11 && exp_cnt < 3) exp_cnt++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1; s_vld = 0; m_rdy = 0;
        tick();
        rst = 0;
    endtask

    task automatic push(input logic [1:0] ty, input logic [7:0] c);
        s_vld = 1; s_type = ty; s_data_common = c; s_data_a = c ^ 8'hA5; s_data_b = c ^ 8'h3C;
    endtask

    task automatic test_reset();
        rst = 1; s_vld = 1; s_type = 2'b01; s_data_a = 8'h5A; m_rdy = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (m_vld !== 1'b0) begin bad++; $display("FAIL reset_m_vld got=%b exp=0", m_vld); end
            total++; if (s_rdy !== 1'b1) begin bad++; $display("FAIL reset_s_rdy got=%b exp=1", s_rdy); end
            total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
            total++; if (err_illegal !== 1'b0 || err_cnt !== '0) begin bad++; $display("FAIL reset_err got=%b/%0d exp=0/0", err_illegal, err_cnt); end
        end
        rst = 0;
        tick();
        s_vld = 0;
        total++; if (m_vld !== 1'b1 || m_type_a !== 1'b1 || m_data_a !== 8'h5A || occupancy !== 2'd1) begin
            bad++; $display("FAIL first_xfer got vld=%b ta=%b a=%h occ=%0d exp 1/1/5a/1", m_vld, m_type_a, m_data_a, occupancy);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        m_rdy = 1;
        for (int i = 0; i < 8; i++) begin
            push(2'(i % 3), 8'(i));
            tick();
            total++; if (m_vld !== 1'b1 || m_data_common !== 8'(i) || occupancy !== 2'd1) begin
                bad++; $display("FAIL b2b_%0d got vld=%b c=%h occ=%0d exp 1/%h/1", i, m_vld, m_data_common, occupancy, 8'(i));
            end
            total++; if (m_type_a !== (i % 3 == 1) || m_type_b !== (i % 3 == 2)) begin
                bad++; $display("FAIL b2b_type_%0d got a=%b b=%b", i, m_type_a, m_type_b);
            end
        end
        s_vld = 0;
    endtask

    task automatic test_stall_skid();
        logic [7:0] seen[$];
        do_reset();
        m_rdy = 1; push(2'b00, 8'h10); tick();
        m_rdy = 0; push(2'b00, 8'h11); tick();
        total++; if (occupancy !== 2'd2 || s_rdy !== 1'b0 || m_data_common !== 8'h10) begin
            bad++; $display("FAIL skid_full got occ=%0d rdy=%b c=%h exp 2/0/10", occupancy, s_rdy, m_data_common);
        end
        push(2'b00, 8'h12);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (m_data_common !== 8'h10 || m_vld !== 1'b1 || occupancy !== 2'd2) begin
                bad++; $display("FAIL skid_hold got c=%h vld=%b occ=%0d exp 10/1/2", m_data_common, m_vld, occupancy);
            end
        end
        m_rdy = 1;
        for (int i = 0; i < 8; i++) begin
            if (m_vld) seen.push_back(m_data_common);
            tick();
            if (mq.size() == 0 || mq[mq.size()-1].c == 8'h12) s_vld = 0;
        end
        total++; if (seen.size() != 3 || seen[0] !== 8'h10 || seen[1] !== 8'h11 || seen[2] !== 8'h12) begin
            bad++; $display("FAIL skid_order got n=%0d exp 3 (10,11,12)", seen.size());
        end
    endtask

    task automatic test_illegal();
        do_reset();
        m_rdy = 1;
        for (int k = 1; k <= 4; k++) begin
            push(2'b11, 8'(8'h40 + k));
            tick();
            total++; if (err_illegal !== 1'b1 || err_cnt !== 2'((k > 3) ? 3 : k)) begin
                bad++; $display("FAIL illegal_%0d got pulse=%b cnt=%0d exp 1/%0d", k, err_illegal, err_cnt, (k > 3) ? 3 : k);
            end
            total++; if (m_type_a !== 1'b0 || m_type_b !== 1'b0 || m_data_common !== 8'(8'h40 + k)) begin
                bad++; $display("FAIL illegal_flags_%0d got a=%b b=%b c=%h", k, m_type_a, m_type_b, m_data_common);
            end
        end
        s_vld = 0; tick();
        total++; if (err_illegal !== 1'b0 || err_cnt !== 2'd3) begin
            bad++; $display("FAIL illegal_idle got pulse=%b cnt=%0d exp 0/3", err_illegal, err_cnt);
        end
    endtask

    task automatic test_reset_full();
        do_reset();
        m_rdy = 0; push(2'b01, 8'h30); tick(); push(2'b10, 8'h31); tick();
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL rf_fill got occ=%0d exp 2", occupancy); end
        rst = 1; tick(); rst = 0; s_vld = 0;
        total++; if (m_vld !== 1'b0 || occupancy !== 2'd0 || s_rdy !== 1'b1) begin
            bad++; $display("FAIL rf_clear got vld=%b occ=%0d rdy=%b exp 0/0/1", m_vld, occupancy, s_rdy);
        end
        m_rdy = 1; push(2'b00, 8'h77); tick(); s_vld = 0;
        total++; if (m_vld !== 1'b1 || m_data_common !== 8'h77 || occupancy !== 2'd1) begin
            bad++; $display("FAIL rf_fresh got vld=%b c=%h occ=%0d exp 1/77/1", m_vld, m_data_common, occupancy);
        end
    endtask

    task automatic test_simul();
        do_reset();
        m_rdy = 0; push(2'b00, 8'h20); tick();
        s_vld = 0; tick();
        total++; if (m_data_common !== 8'h20 || occupancy !== 2'd1) begin
            bad++; $display("FAIL simul_pre got c=%h occ=%0d exp 20/1", m_data_common, occupancy);
        end
        m_rdy = 1; push(2'b10, 8'h21); tick(); s_vld = 0; m_rdy = 0;
        total++; if (m_data_common !== 8'h21 || occupancy !== 2'd1 || m_type_b !== 1'b1) begin
            bad++; $display("FAIL simul got c=%h occ=%0d tb=%b exp 21/1/1", m_data_common, occupancy, m_type_b);
        end
    endtask

    task automatic test_random();
        bit blocked;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            blocked = !rst && s_vld && (mq.size() >= 2);
            if (!blocked) begin
                s_vld = ($urandom_range(0, 3) != 0);
                s_type = 2'($urandom);
                s_data_common = 8'($urandom); s_data_a = 8'($urandom); s_data_b = 8'($urandom);
            end
            m_rdy = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 99) == 0);
            tick();
            total++; if (m_vld !== (mq.size() > 0) || occupancy !== 2'(mq.size()) || s_rdy !== (mq.size() < 2)) begin
                bad++; $display("FAIL rnd_ctl_%0d got vld=%b occ=%0d rdy=%b exp occ=%0d", n, m_vld, occupancy, s_rdy, mq.size());
            end
            total++; if (err_illegal !== exp_err || err_cnt !== 2'(exp_cnt)) begin
                bad++; $display("FAIL rnd_err_%0d got %b/%0d exp %b/%0d", n, err_illegal, err_cnt, exp_err, exp_cnt);
            end
            if (mq.size() > 0) begin
                total++; if (m_data_common !== mq[0].c || m_data_a !== mq[0].a || m_data_b !== mq[0].b ||
                             m_type_a !== (mq[0].ty == 2'b01) || m_type_b !== (mq[0].ty == 2'b10)) begin
                    bad++; $display("FAIL rnd_head_%0d got c=%h a=%h b=%h ta=%b tb=%b exp c=%h a=%h b=%h ty=%0d",
                                    n, m_data_common, m_data_a, m_data_b, m_type_a, m_type_b, mq[0].c, mq[0].a, mq[0].b, mq[0].ty);
                end
            end
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall_skid();
        test_illegal();
        test_reset_full();
        test_simul();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
